// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and types for the three-bus system interconnect
//   WORD_W       - bus word width
//   address map  - start addresses of ROM, stack and memory/IO responder windows
//   resp_state_t - bus-cycle phase of a memory-mapped responder
package bus_pkg;
   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] ROM_START   = 16'h0000;
   localparam logic [WORD_W-1:0] STACK_START = 16'h7E00;
   localparam logic [WORD_W-1:0] STACK_POINT = 16'h7FFF;
   localparam logic [WORD_W-1:0] MEM_BASE    = 16'h8000;
   localparam logic [WORD_W-1:0] IO_BASE     = 16'hF000;
   typedef enum logic [1:0] {IDLE, FETCH, DRIVE} resp_state_t;
endpackage

// File: rtl/sync_ram_1r1w.sv
// sync_ram_1r1w: one-read one-write synchronous RAM
//   clk            - clock
//   re/raddr/rdata - read port, rdata registered (1-cycle latency), holds when re=0
//   we/waddr/wdata - write port; a same-address read returns the old word
module sync_ram_1r1w #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: RAM-backed responder on the read_bus/data_bus/write_bus interconnect
//   clk, reset_n        - clock, asynchronous active-low reset
//   enabled             - gates decode, drive and RAM writes
//   ctrl_stb/read_stb/write_stb - bus-cycle phase strobes
//   read_bus/write_bus  - read and write addresses
//   data_bus            - shared tristate data bus
//   busy                - bus-cycle FSM active
//   proto_err/err_clr   - sticky protocol-violation flag and its clear
module bus_mem_responder import bus_pkg::*; #(
   parameter int WORD_W = bus_pkg::WORD_W,
   parameter int unsigned ADDR_BASE = 32'h8000,
   parameter int DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enabled,
   input  logic              ctrl_stb,
   input  logic              read_stb,
   input  logic              write_stb,
   input  logic [WORD_W-1:0] read_bus,
   input  logic [WORD_W-1:0] write_bus,
   inout  wire  [WORD_W-1:0] data_bus,
   output logic              busy,
   output logic              proto_err,
   input  logic              err_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [WORD_W-1:0] BASE = WORD_W'(ADDR_BASE);
   // one bit wider so the window end never wraps at the top of the address space
   localparam logic [WORD_W:0] LIMIT = (WORD_W+1)'(ADDR_BASE + DEPTH);

   function automatic logic hit(input logic [WORD_W-1:0] a);
      return a >= BASE && {1'b0, a} < LIMIT;
   endfunction

   resp_state_t state;
   logic data_oe, do_read, do_write, multi, err_now;
   logic [WORD_W-1:0] drive_q, rdata;

   // a write phase always wins over a read in the same cycle
   assign do_read  = enabled && read_stb && !write_stb && hit(read_bus);
   assign do_write = enabled && write_stb && hit(write_bus);
   assign multi    = (ctrl_stb && read_stb) || (ctrl_stb && write_stb) || (read_stb && write_stb);
   assign err_now  = enabled && (multi || (write_stb && state == FETCH) ||
                     ((ctrl_stb || read_stb) && state != IDLE));
   assign busy     = state != IDLE;
   assign data_bus = data_oe ? drive_q : {WORD_W{1'bz}};

   sync_ram_1r1w #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .re    (do_read),
      .raddr (AW'(read_bus - BASE)),
      .rdata (rdata),
      .we    (do_write),
      .waddr (AW'(write_bus - BASE)),
      .wdata (data_bus)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         data_oe   <= 1'b0;
         drive_q   <= '0;
         proto_err <= 1'b0;
      end else begin
         proto_err <= err_now || (proto_err && !err_clr);
         data_oe   <= 1'b0;
         if (!enabled || write_stb || (ctrl_stb && state != IDLE)) state <= IDLE;
         else if (read_stb) state <= do_read ? FETCH : IDLE;
         else if (state == FETCH) begin
            state   <= DRIVE;
            drive_q <= rdata;
            data_oe <= 1'b1;
         end else data_oe <= state == DRIVE;
      end
   end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed and random bus cycles checked against a behavioural model
module tb_bus_mem_responder;
   logic clk = 1'b0, reset_n = 1'b0, enabled = 1'b0, err_clr = 1'b0;
   logic ctrl_stb = 1'b0, read_stb = 1'b0, write_stb = 1'b0, tb_oe = 1'b0;
   logic [15:0] read_bus = '0, write_bus = '0, tb_data = '0;
   wire  [15:0] data_bus;
   logic busy, proto_err;
   int vectors = 0, miscompares = 0;

   // model: word store, cycles since an accepted read hit (0 = none), captured word, error flag
   logic [15:0] mem [256];
   int age = 0;
   logic [15:0] rv = '0;
   logic m_err = 1'b0;

   assign data_bus = tb_oe ? tb_data : 'z;
   pullup (data_bus);
   always #5 clk = ~clk;

   bus_mem_responder dut (
      .clk(clk), .reset_n(reset_n), .enabled(enabled), .ctrl_stb(ctrl_stb),
      .read_stb(read_stb), .write_stb(write_stb), .read_bus(read_bus),
      .write_bus(write_bus), .data_bus(data_bus), .busy(busy),
      .proto_err(proto_err), .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_win(input logic [15:0] a);
      return int'(a) >= 'h8000 && int'(a) < 'h8100;
   endfunction

   function automatic int idx(input logic [15:0] a);
      return int'(a) - 'h8000;
   endfunction

   // one bus clock: apply inputs, check outputs mid-cycle, advance the model at the edge
   task automatic cyc(input logic c, input logic r, input logic w, input logic [15:0] ra,
                      input logic [15:0] wa, input logic [15:0] wd,
                      input logic clr = 1'b0, input logic en = 1'b1);
      logic drv, err;
      logic [15:0] bus;
      drv = age >= 2;
      ctrl_stb = c; read_stb = r; write_stb = w; read_bus = ra; write_bus = wa;
      err_clr = clr; enabled = en;
      tb_oe = w && !drv;
      tb_data = wd;
      bus = drv ? rv : (tb_oe ? wd : 16'hFFFF);
      @(negedge clk);
      check("busy", {15'd0, busy}, {15'd0, age > 0});
      check("proto_err", {15'd0, proto_err}, {15'd0, m_err});
      check("data_bus", data_bus, bus);
      @(posedge clk);
      err = 1'b0;
      if (!en) age = 0;
      else begin
         err = int'(c) + int'(r) + int'(w) > 1 || (w && age == 1) || ((c || r) && age > 0);
         if (w && in_win(wa)) mem[idx(wa)] = bus;
         if (w || (c && age > 0)) age = 0;
         else if (r) begin
            age = in_win(ra) ? 1 : 0;
            if (in_win(ra)) rv = mem[idx(ra)];
         end else if (age > 0) age++;
      end
      m_err = err || (m_err && !clr);
      #1;
      ctrl_stb = 1'b0; read_stb = 1'b0; write_stb = 1'b0; err_clr = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic rd(input logic [15:0] a);
      cyc(1'b0, 1'b1, 1'b0, a, '0, '0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      cyc(1'b0, 1'b0, 1'b1, '0, a, d);
   endtask

   initial begin
      #3;
      check("reset_busy", {15'd0, busy}, 16'd0);
      check("reset_err", {15'd0, proto_err}, 16'd0);
      check("reset_bus", data_bus, 16'hFFFF);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 256; i++) wr(16'(16'h8000 + i), 16'($urandom_range(0, 16'hFFFE)));
      // write then read back
      wr(16'h8005, 16'hBEEF);
      cyc(1'b1, 1'b0, 1'b0, 16'h8005, '0, '0);
      rd(16'h8005);
      idle(1);
      check("beef_drive", data_bus, 16'hBEEF);
      idle(1);
      wr(16'h0000, 16'h0000);
      check("beef_release", data_bus, 16'hFFFF);
      check("beef_err", {15'd0, proto_err}, 16'd0);
      // window edges
      rd(16'h80FF);
      idle(2);
      wr(16'h0000, 16'h0000);
      rd(16'h8100);
      check("miss_hi_busy", {15'd0, busy}, 16'd0);
      idle(2);
      rd(16'h7FFF);
      check("miss_lo_busy", {15'd0, busy}, 16'd0);
      idle(2);
      wr(16'h8100, 16'h5555);
      rd(16'h8000);
      idle(2);
      wr(16'h0000, 16'h0000);
      // same-address read and write in one bus cycle
      wr(16'h8003, 16'h1234);
      rd(16'h8003);
      idle(2);
      wr(16'h8003, 16'h0F0F);
      rd(16'h8003);
      idle(1);
      check("same_addr", data_bus, 16'h1234);
      idle(1);
      wr(16'h0000, 16'h0000);
      // write phase during FETCH
      rd(16'h8010);
      wr(16'h0000, 16'h0000);
      check("short_err", {15'd0, proto_err}, 16'd1);
      check("short_busy", {15'd0, busy}, 16'd0);
      idle(2);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      check("short_clr", {15'd0, proto_err}, 16'd0);
      // missing write phase
      rd(16'h8020);
      idle(2);
      cyc(1'b1, 1'b0, 1'b0, '0, '0, '0);
      check("nowr_bus", data_bus, 16'hFFFF);
      check("nowr_err", {15'd0, proto_err}, 16'd1);
      check("nowr_busy", {15'd0, busy}, 16'd0);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      // enable dropped mid-drive: release without error
      rd(16'h8005);
      idle(2);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      idle(2);
      // asynchronous reset mid-drive
      rd(16'h8005);
      idle(2);
      reset_n = 1'b0;
      #1;
      check("arst_bus", data_bus, 16'hFFFF);
      check("arst_busy", {15'd0, busy}, 16'd0);
      age = 0;
      m_err = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      rd(16'h8005);
      idle(1);
      check("arst_keep", data_bus, 16'hBEEF);
      idle(1);
      wr(16'h0000, 16'h0000);
      // random bus traffic including protocol violations
      for (int n = 0; n < 3000; n++) begin
         int p;
         logic [15:0] ra, wa, wd;
         p  = int'($urandom_range(0, 9));
         ra = 16'($urandom_range(16'h7FF0, 16'h8110));
         wa = 16'($urandom_range(16'h7FF0, 16'h8110));
         wd = 16'($urandom_range(0, 16'hFFFE));
         cyc(p == 5 || p == 9, p == 6 || p == 8, p >= 7, ra, wa, wd,
             $urandom_range(0, 15) == 0, $urandom_range(0, 31) != 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
